column_parity: RTL and testbench

Column-parity (theta) stage of the encoder round datapath, started by the round controller through its `start_par`/`ready_par` handshake. It reads the 25 lanes of the 5x5 state from the shared single-port state memory and accumulates the five column parities C[x]. It then derives D[x] and rewrites every lane in place as A[x][y] ^ D[x]. When it finishes, it returns `ready` high so the controller can advance to the rotate stage.

---
 rtl/encoder_pkg.sv | 27 ++
 rtl/theta_d_unit.sv | 17 +
 rtl/column_parity.sv | 131 +++++++++++++
 tb/tb_column_parity.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/encoder_pkg.sv
// Shared definitions for the encoder round datapath: lane geometry, the
// column-parity FSM encoding and small lane helpers.
package encoder_pkg;

  localparam int LANE_W    = 64;
  localparam int NUM_LANES = 25;
  localparam int ROW_SZ    = 5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_C,
    S_RD_TAIL,
    S_CALC_D,
    S_UPD_RD,
    S_UPD_WR
  } cp_state_e;

  // Lane (x,y) sits at 5*y + x; x,y are always 0..4 so 5 bits suffice.
  function automatic logic [4:0] lane_addr(input logic [2:0] x, input logic [2:0] y);
    return ({2'b00, y} * 5'd5) + {2'b00, x};
  endfunction

  function automatic logic [LANE_W-1:0] rotl1(input logic [LANE_W-1:0] v);
    return {v[LANE_W-2:0], v[LANE_W-1]};
  endfunction

endpackage

// File: rtl/theta_d_unit.sv
// Combinational theta D term: D[x] = C[x-1] ^ rotl(C[x+1], 1), indices mod 5.
module theta_d_unit
  import encoder_pkg::*;
#(
  parameter int W = LANE_W
) (
  input  logic [ROW_SZ-1:0][W-1:0] i_c,
  output logic [ROW_SZ-1:0][W-1:0] o_d
);

  for (genvar gx = 0; gx < ROW_SZ; gx++) begin : g_col
    localparam int XM = (gx + ROW_SZ - 1) % ROW_SZ;
    localparam int XP = (gx + 1) % ROW_SZ;
    assign o_d[gx] = i_c[XM] ^ {i_c[XP][W-2:0], i_c[XP][W-1]};
  end

endmodule

// File: rtl/column_parity.sv
// Theta stage: accumulates column parities over the 25 lanes of the state
// memory, derives D and rewrites every lane in place as A ^ D[x].
module column_parity
  import encoder_pkg::*;
#(
  parameter int W  = LANE_W,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          ready,
  output logic [AW-1:0] mem_addr,
  output logic          mem_re,
  input  logic [W-1:0]  mem_rdata,
  output logic          mem_we,
  output logic [W-1:0]  mem_wdata
);

  cp_state_e                 r_state;
  logic [ROW_SZ-1:0][W-1:0]  r_c;
  logic [ROW_SZ-1:0][W-1:0]  r_d;
  logic [2:0]                r_x, r_y, r_xd;
  logic                      r_first;
  logic                      r_ready;
  logic                      r_re;
  logic                      r_we;
  logic [AW-1:0]             r_addr;

  logic [ROW_SZ-1:0][W-1:0]  w_d;
  logic [2:0]                w_nx, w_ny;
  logic [AW-1:0]             w_naddr;
  logic                      w_last;

  theta_d_unit #(.W(W)) u_theta_d (
    .i_c (r_c),
    .o_d (w_d)
  );

  // x/y always track the lane currently on mem_addr.
  assign w_last  = (r_addr == AW'(NUM_LANES - 1));
  assign w_nx    = (r_x == 3'd4) ? 3'd0 : r_x + 3'd1;
  assign w_ny    = (r_x == 3'd4) ? r_y + 3'd1 : r_y;
  assign w_naddr = AW'(lane_addr(w_nx, w_ny));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_c     <= '0;
      r_d     <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_xd    <= '0;
      r_first <= 1'b0;
      r_ready <= 1'b1;
      r_re    <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_c     <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_xd    <= '0;
            r_first <= 1'b1;
            r_addr  <= '0;
            r_re    <= 1'b1;
            r_ready <= 1'b0;
            r_state <= S_RD_C;
          end
        end
        S_RD_C: begin
          // Read data lags the address by one cycle, so fold in lane x_d.
          if (!r_first) r_c[r_xd] <= r_c[r_xd] ^ mem_rdata;
          r_first <= 1'b0;
          r_xd    <= r_x;
          if (w_last) begin
            r_re    <= 1'b0;
            r_state <= S_RD_TAIL;
          end else begin
            r_x    <= w_nx;
            r_y    <= w_ny;
            r_addr <= w_naddr;
          end
        end
        S_RD_TAIL: begin
          r_c[r_xd] <= r_c[r_xd] ^ mem_rdata;
          r_state   <= S_CALC_D;
        end
        S_CALC_D: begin
          r_d     <= w_d;
          r_x     <= '0;
          r_y     <= '0;
          r_addr  <= '0;
          r_re    <= 1'b1;
          r_state <= S_UPD_RD;
        end
        S_UPD_RD: begin
          r_re    <= 1'b0;
          r_we    <= 1'b1;
          r_state <= S_UPD_WR;
        end
        S_UPD_WR: begin
          r_we <= 1'b0;
          if (w_last) begin
            r_addr  <= '0;
            r_ready <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_x     <= w_nx;
            r_y     <= w_ny;
            r_addr  <= w_naddr;
            r_re    <= 1'b1;
            r_state <= S_UPD_RD;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ready    = r_ready;
  assign mem_addr = r_addr;
  assign mem_re   = r_re;
  assign mem_we   = r_we;
  // Write data comes straight off the read port during the write cycle.
  assign mem_wdata = r_we ? (mem_rdata ^ r_d[r_x]) : '0;

endmodule

// File: tb/tb_column_parity.sv
// Scoreboard bench for column_parity: memory model, expected write queue
// and an independent theta model over the whole state.
module tb_column_parity;
  import encoder_pkg::*;

  typedef logic [24:0][63:0] st_t;
  typedef logic [4:0][63:0]  col_t;
  typedef struct {
    logic [4:0]  a;
    logic [63:0] d;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        ready;
  logic [4:0]  mem_addr;
  logic        mem_re;
  logic [63:0] mem_rdata;
  logic        mem_we;
  logic [63:0] mem_wdata;

  st_t  mem;
  st_t  gm;
  st_t  ld_val;
  logic ld = 1'b0;
  col_t ref_c, ref_d;

  wr_t q[$];
  int  n_chk = 0, n_fail = 0;
  int  cnt_busy = 0, cnt_re = 0, cnt_we = 0;

  always #5 clk = ~clk;

  column_parity #(.W(64), .AW(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .ready     (ready),
    .mem_addr  (mem_addr),
    .mem_re    (mem_re),
    .mem_rdata (mem_rdata),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata)
  );

  theta_d_unit #(.W(64)) u_ref_d (.i_c(ref_c), .o_d(ref_d));

  always @(posedge clk) begin
    if (ld) mem <= ld_val;
    else begin
      if (mem_re) mem_rdata <= mem[mem_addr];
      if (mem_we) mem[mem_addr] <= mem_wdata;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!ready) cnt_busy++;
    if (mem_re) cnt_re++;
    if (mem_re || mem_we) chk("re_we_excl", 64'(mem_re & mem_we), 64'd0);
    if (mem_we) begin
      cnt_we++;
      if (q.size() == 0) chk("wr_unexpected", 64'd1, 64'd0);
      else begin
        wr_t e;
        e = q.pop_front();
        chk("wr_addr", 64'(mem_addr), 64'(e.a));
        chk("wr_data", mem_wdata, e.d);
      end
    end
  end

  function automatic col_t cols(input st_t a);
    col_t c = '0;
    for (int y = 0; y < 5; y++)
      for (int x = 0; x < 5; x++) c[x] ^= a[5*y+x];
    return c;
  endfunction

  function automatic col_t d_of(input col_t c);
    col_t d;
    for (int x = 0; x < 5; x++) begin
      logic [63:0] p;
      p = c[(x+1)%5];
      d[x] = c[(x+4)%5] ^ {p[62:0], p[63]};
    end
    return d;
  endfunction

  function automatic st_t theta(input st_t a);
    col_t d;
    st_t  r;
    d = d_of(cols(a));
    for (int i = 0; i < 25; i++) r[i] = a[i] ^ d[i%5];
    return r;
  endfunction

  task automatic load(input st_t s);
    @(negedge clk);
    ld_val = s;
    ld = 1'b1;
    @(negedge clk);
    ld = 1'b0;
    gm = s;
  endtask

  task automatic push_exp(input int nops);
    for (int k = 0; k < nops; k++) begin
      gm = theta(gm);
      for (int i = 0; i < 25; i++) q.push_back('{a: 5'(i), d: gm[i]});
    end
  endtask

  // Called at a negedge; start stays high for hold extra edges after E0.
  task automatic run_op(input int hold, input int nops);
    int we0, busy0, re0, g;
    we0 = cnt_we; busy0 = cnt_busy; re0 = cnt_re;
    start = 1'b1;
    @(posedge clk);
    repeat (hold) @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    g = 0;
    while (!(ready && (cnt_we - we0) == 25*nops) && g < 200*nops) begin
      @(negedge clk);
      g++;
    end
    chk("op_writes", 64'(cnt_we - we0), 64'(25*nops));
    chk("op_busy", 64'(cnt_busy - busy0), 64'(77*nops));
    chk("op_reads", 64'(cnt_re - re0), 64'(50*nops));
  endtask

  task automatic chk_mem(input string tag);
    int nbad = 0;
    for (int i = 0; i < 25; i++) if (mem[i] !== gm[i]) nbad++;
    chk(tag, 64'(nbad), 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    st_t s, full;
    col_t c;
    ref_c = '0;
    #1 rst = 1'b0;
    #1;
    chk("rst_ready", 64'(ready), 64'd1);
    chk("rst_re", 64'(mem_re), 64'd0);
    chk("rst_we", 64'(mem_we), 64'd0);
    chk("rst_addr", 64'(mem_addr), 64'd0);
    chk("rst_wdata", mem_wdata, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // all-zero state
    load('0);
    push_exp(1);
    run_op(0, 1);
    chk_mem("zero_mem");

    // single bit in lane (0,0)
    s = '0; s[0] = 64'h1;
    load(s);
    push_exp(1);
    run_op(0, 1);
    chk_mem("l00_mem");
    chk("l00_lane0", mem[0], 64'h1);
    chk("l00_lane1", mem[1], 64'h1);
    chk("l00_lane21", mem[21], 64'h1);
    chk("l00_lane4", mem[4], 64'h2);
    chk("l00_lane24", mem[24], 64'h2);
    chk("l00_lane2", mem[2], 64'h0);

    // rotate wrap from lane (2,3)
    s = '0; s[17] = 64'h8000_0000_0000_0000;
    load(s);
    push_exp(1);
    run_op(0, 1);
    chk_mem("wrap_mem");
    chk("wrap_lane1", mem[1], 64'h1);
    chk("wrap_lane3", mem[3], 64'h8000_0000_0000_0000);
    chk("wrap_lane17", mem[17], 64'h8000_0000_0000_0000);
    chk("wrap_lane0", mem[0], 64'h0);

    // start held through E76 -> one op; held through E78 -> two ops
    for (int i = 0; i < 25; i++) s[i] = {$urandom, $urandom};
    load(s);
    push_exp(1);
    run_op(76, 1);
    repeat (3) @(negedge clk);
    chk("hold_idle", 64'(ready), 64'd1);
    chk_mem("hold_mem");
    push_exp(2);
    run_op(78, 2);
    chk_mem("hold2_mem");

    // reset mid-operation after lanes 0 and 1 are written
    for (int i = 0; i < 25; i++) s[i] = {$urandom, $urandom};
    load(s);
    push_exp(1);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (31) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst_ready", 64'(ready), 64'd1);
    chk("mid_rst_re", 64'(mem_re), 64'd0);
    chk("mid_rst_we", 64'(mem_we), 64'd0);
    chk("mid_rst_addr", 64'(mem_addr), 64'd0);
    q.delete();
    full = theta(s);
    gm = s; gm[0] = full[0]; gm[1] = full[1];
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_mem("mid_rst_mem");
    push_exp(1);
    run_op(0, 1);
    chk_mem("post_rst_mem");

    // random states, back-to-back
    for (int n = 0; n < 200; n++) begin
      for (int i = 0; i < 25; i++) s[i] = {$urandom, $urandom};
      c = cols(s);
      ref_c = c;
      #1;
      chk("ref_d_unit", 64'(ref_d == d_of(c)), 64'd1);
      load(s);
      push_exp(1);
      run_op(0, 1);
      chk_mem("rand_mem");
    end
    chk("queue_empty", 64'(q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
